// File: rtl/d8m_pkg.sv
// d8m_pkg
// Shared definitions for the D8M read-side path: counter width, default
// frame geometry (also used by the line buffer and demosaic stage), and the
// read scheduler state encoding.
package d8m_pkg;

  localparam int CNT_W            = 13;
  localparam int H_PIXELS_DEF     = 640;
  localparam int V_LINES_DEF      = 480;
  localparam int VAL_LINE_MIN_DEF = 2;
  localparam int VAL_LINE_MAX_DEF = 620;
  localparam int CREDIT_MAX_DEF   = 2;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LINE,
    READ,
    LINE_END,
    DONE
  } rd_state_e;

endpackage

// File: rtl/d8m_tgl_sync.sv
// d8m_tgl_sync
// Brings a toggle-encoded event from the CCD pixel clock domain into the
// local clock domain and turns each toggle into a one-cycle pulse.
// Ports:
//   i_clk    local clock
//   i_rst_n  asynchronous active-low reset
//   i_tgl    toggle input, asynchronous to i_clk
//   o_pulse  one-cycle pulse per toggle, 3 clocks after the input change
module d8m_tgl_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_tgl,
  output logic o_pulse
);

  logic r_s1;
  logic r_s2;
  logic r_edge;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_s1   <= i_tgl;
      r_s2   <= r_s1;
      r_edge <= r_s2;
    end
  end

  // Either toggle direction is one event.
  assign o_pulse = r_s2 ^ r_edge;

endmodule

// File: rtl/d8m_line_read_sched.sv
// d8m_line_read_sched
// Read-side scheduler for the D8M line buffer in the VGA_CLK domain. Turns
// VGA timing into the line-buffer read strobe plus pixel and line counters,
// and (optionally) tracks written-vs-read line credit.
// Build option: D8M_RD_CREDIT_EN enables the line-done synchronizer, the
// credit counter and the oERR flags; without it oERR is 0 and iLINE_TGL is
// ignored.
// Ports:
//   VGA_CLK, RST_N   pixel clock, async active-low reset
//   VGA_VS           vertical sync (active low), falling edge = frame start
//   iH_ACTIVE        horizontal active from the timing generator
//   iLINE_TGL        camera line-complete toggle (CCD domain)
//   READ_EN          registered line-buffer read strobe
//   READ_Cont        pixel index in the current line
//   V_Cont           line index in the frame
//   oRD_WIN          READ_EN inside the (MIN, MAX) pixel window
//   oFRAME_START     one-cycle frame start pulse
//   oERR             sticky [0] underrun, [1] overflow
//
// state     | meaning
// IDLE      | after reset, waiting for first frame start
// WAIT_LINE | waiting for iH_ACTIVE rise
// READ      | strobing the line buffer, counting pixels
// LINE_END  | one cycle, advance V_Cont
// DONE      | frame complete, waiting for next frame start
module d8m_line_read_sched
  import d8m_pkg::*;
#(
  parameter int H_PIXELS     = H_PIXELS_DEF,
  parameter int V_LINES      = V_LINES_DEF,
  parameter int VAL_LINE_MIN = VAL_LINE_MIN_DEF,
  parameter int VAL_LINE_MAX = VAL_LINE_MAX_DEF,
  parameter int CREDIT_MAX   = CREDIT_MAX_DEF
) (
  input  logic             VGA_CLK,
  input  logic             RST_N,
  input  logic             VGA_VS,
  input  logic             iH_ACTIVE,
  input  logic             iLINE_TGL,
  output logic             READ_EN,
  output logic [CNT_W-1:0] READ_Cont,
  output logic [CNT_W-1:0] V_Cont,
  output logic             oRD_WIN,
  output logic             oFRAME_START,
  output logic [1:0]       oERR
);

  rd_state_e        r_state;
  logic             r_vs_d;
  logic             r_hact_d;
  logic             r_rise_pend;
  logic             w_vs_fall;
  logic             w_h_rise;
  logic             w_go_read;
  logic             w_last_pix;
  logic [CNT_W-1:0] w_v_next;

  assign w_vs_fall  = r_vs_d & ~VGA_VS;
  assign w_h_rise   = iH_ACTIVE & ~r_hact_d;
  // A rise seen during LINE_END is held one cycle so WAIT_LINE still acts on it.
  assign w_go_read  = (r_state == WAIT_LINE) && (w_h_rise || r_rise_pend);
  assign w_last_pix = (READ_Cont == CNT_W'(H_PIXELS - 1));
  assign w_v_next   = V_Cont + 1'b1;

  assign oRD_WIN = READ_EN && (READ_Cont > CNT_W'(VAL_LINE_MIN))
                           && (READ_Cont < CNT_W'(VAL_LINE_MAX));

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state      <= IDLE;
      r_vs_d       <= 1'b1;
      r_hact_d     <= 1'b0;
      r_rise_pend  <= 1'b0;
      READ_EN      <= 1'b0;
      READ_Cont    <= '0;
      V_Cont       <= '0;
      oFRAME_START <= 1'b0;
    end else begin
      r_vs_d       <= VGA_VS;
      r_hact_d     <= iH_ACTIVE;
      oFRAME_START <= w_vs_fall;
      r_rise_pend  <= !w_vs_fall && (r_state == LINE_END) && w_h_rise;
      if (w_vs_fall) begin
        r_state   <= WAIT_LINE;
        READ_EN   <= 1'b0;
        READ_Cont <= '0;
        V_Cont    <= '0;
      end else begin
        case (r_state)
          WAIT_LINE: begin
            if (w_go_read) begin
              r_state   <= READ;
              READ_EN   <= 1'b1;
              READ_Cont <= '0;
            end
          end
          READ: begin
            READ_Cont <= READ_Cont + 1'b1;
            if (!iH_ACTIVE || w_last_pix) begin
              READ_EN <= 1'b0;
              r_state <= LINE_END;
            end
          end
          LINE_END: begin
            V_Cont    <= w_v_next;
            READ_Cont <= '0;
            r_state   <= (w_v_next == CNT_W'(V_LINES)) ? DONE : WAIT_LINE;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef D8M_RD_CREDIT_EN
  localparam int CREDIT_W = $clog2(CREDIT_MAX + 1);

  logic [CREDIT_W-1:0] r_credit;
  logic                w_line_done;
  logic                w_consume;

  d8m_tgl_sync u_line_sync (
    .i_clk   (VGA_CLK),
    .i_rst_n (RST_N),
    .i_tgl   (iLINE_TGL),
    .o_pulse (w_line_done)
  );

  // An underrun read does not consume: there is nothing to take.
  assign w_consume = w_go_read && (r_credit != '0);

  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_credit <= '0;
      oERR     <= 2'b00;
    end else if (w_vs_fall) begin
      r_credit <= '0;
      oERR     <= 2'b00;
    end else begin
      if (w_go_read && (r_credit == '0)) begin
        oERR[0] <= 1'b1;
      end
      if (w_line_done && !w_consume) begin
        if (r_credit == CREDIT_W'(CREDIT_MAX)) begin
          oERR[1] <= 1'b1;
        end else begin
          r_credit <= r_credit + 1'b1;
        end
      end else if (w_consume && !w_line_done) begin
        r_credit <= r_credit - 1'b1;
      end
    end
  end
`else
  localparam int UNUSED_CREDIT_MAX = CREDIT_MAX;
  logic w_unused_tgl;
  assign w_unused_tgl = iLINE_TGL;
  assign oERR         = 2'b00;
`endif

endmodule

// File: doc/d8m_line_read_sched.md
# d8m_line_read_sched

Read-side scheduler for the D8M camera line buffer and Bayer demosaic path, in the VGA_CLK domain. It converts VGA timing into the line-buffer read strobe, the horizontal read counter and the line counter. It tracks camera lines written versus lines read with a credit counter and flags underrun and overflow. It sits between the VGA timing generator and the RAW-to-RGB line buffer and binning stage.

## Interface
- H_PIXELS, 640, pixels read per line; READ_EN drops after this many
- V_LINES, 480, lines read per frame before going idle
- VAL_LINE_MIN, 2, lower exclusive bound of the valid read window on READ_Cont
- VAL_LINE_MAX, 620, upper exclusive bound of the valid read window
- CREDIT_MAX, 2, line-buffer depth in lines
- VGA_CLK  in  1  read-side pixel clock, 25 MHz
- RST_N  in  1  asynchronous, active-low reset
- VGA_VS  in  1  vertical sync, active-low; its falling edge marks frame start
- iH_ACTIVE  in  1  horizontal active from the VGA timing generator
- iLINE_TGL  in  1  toggles once per completed camera line (CCD_PIXCLK domain, asynchronous)
- READ_EN  out  1  line-buffer read strobe
- READ_Cont  out  13  pixel index within the current read line
- V_Cont  out  13  line index within the frame
- oRD_WIN  out  1  high when VAL_LINE_MIN < READ_Cont < VAL_LINE_MAX and READ_EN is high
- oFRAME_START  out  1  one-cycle pulse on the detected VGA_VS falling edge
- oERR  out  2  sticky flags: [0] underrun, [1] overflow; cleared at frame start

## Operation
- Reset values: all outputs 0; state IDLE; credit 0; synchronizer and edge registers 0; VGA_VS history register 1.
- iLINE_TGL passes through a 2-FF synchronizer. An edge detector on the synchronized value produces one line_done pulse per toggle.
- Credit counter, 0..CREDIT_MAX:
  - +1 on line_done.
  - −1 on entry to READ.
  - Both in the same cycle: credit unchanged.
  - line_done at CREDIT_MAX with no simultaneous consume: credit saturates and oERR[1] is set.
- States:
  - IDLE: waits for a VGA_VS falling edge.
  - WAIT_LINE: waits for iH_ACTIVE to rise.
  - READ: drives READ_EN and counts pixels.
  - LINE_END: advances V_Cont.
  - DONE: ignores iH_ACTIVE until the next VGA_VS falling edge.
- A VGA_VS falling edge in any state forces WAIT_LINE and, on the next cycle:
  - pulses oFRAME_START;
  - sets V_Cont and READ_Cont to 0, clears credit and oERR, and drops READ_EN.
  - A line_done in the same cycle is discarded.
- WAIT_LINE→READ on the iH_ACTIVE rising edge.
  - If credit is 0, set oERR[0]. The read still proceeds and stale buffer data is accepted.
  - Otherwise consume one credit.
- In READ, READ_Cont increments on every cycle READ_EN is high.
  - READ→LINE_END when iH_ACTIVE falls or when READ_Cont = H_PIXELS−1, whichever comes first.
  - A short line still advances V_Cont.
- LINE_END is one cycle. V_Cont increments, READ_Cont is set to 0, and the next state is:
  - DONE if the new V_Cont = V_LINES;
  - WAIT_LINE otherwise.
- Arithmetic: 13-bit unsigned. Counters never wrap because they are bounded by the parameters. Window comparisons are unsigned and strict.

## Timing
- READ_EN is registered. It rises 1 cycle after iH_ACTIVE rises; the first strobe carries READ_Cont = 0.
- READ_EN falls 1 cycle after iH_ACTIVE falls, or in the cycle after READ_Cont = H_PIXELS−1 is presented.
- Exactly H_PIXELS strobes are issued per full-length line.
- oRD_WIN is combinational from registered READ_Cont and READ_EN, so it is aligned with them.
- V_Cont changes only in LINE_END, or at frame start. It holds steady for the whole READ interval.
- line_done appears 3 VGA_CLK cycles after the iLINE_TGL change (2 synchronizer stages + edge register).
- iH_ACTIVE rising while still in LINE_END is not lost: the edge is registered and acted on in WAIT_LINE the next cycle.
- Reset asserted mid-line drops READ_EN immediately (asynchronously) and returns to IDLE.

## Configuration
- D8M_RD_CREDIT_EN defined: synchronizer, credit counter and oERR are active as described.
- D8M_RD_CREDIT_EN undefined:
  - iLINE_TGL is ignored and no synchronizer is instantiated.
  - oERR is tied to 0.
  - WAIT_LINE→READ occurs on every iH_ACTIVE rise unconditionally.
  - All other timing is unchanged.

## Structure
- Shared package d8m_pkg holds:
  - the state enum (IDLE, WAIT_LINE, READ, LINE_END, DONE);
  - the 13-bit counter width constant;
  - the default H_PIXELS, V_LINES, VAL_LINE_MIN and VAL_LINE_MAX values, shared with the line buffer and demosaic stage.
- One sub-module, d8m_tgl_sync: the 2-FF synchronizer plus toggle-edge pulse generator, reusable for other CCD→VGA events.

## Test plan
- **Frame start:** reset, VGA_VS 1→0 → oFRAME_START pulses for 1 cycle; V_Cont=0; oERR=0.
- **Full line:** 2 toggles on iLINE_TGL, then iH_ACTIVE high for 700 cycles → exactly 640 READ_EN cycles with READ_Cont 0..639; oRD_WIN high for READ_Cont 3..619; V_Cont goes 0→1; oERR=0.
- **Underrun:** no toggles, iH_ACTIVE rises → oERR[0]=1 on READ entry; the line is still read (640 strobes).
- **Overflow:** 3 toggles, no reads → credit=2, oERR[1]=1. Simultaneous toggle and READ entry at credit 1 → credit stays 1.
- **Frame end and mid-line vsync:**
  - After 480 lines → DONE; further iH_ACTIVE pulses produce no READ_EN.
  - VGA_VS falling edge at READ_Cont=100 → READ_EN low next cycle; V_Cont=0; READ_Cont=0.
- **Credit disabled:** with D8M_RD_CREDIT_EN undefined and iLINE_TGL idle → lines read normally; oERR stays 0.
